// File: rtl/mul_int_pipe.sv
// mul_int_pipe: pipelined multi-lane integer multiplier with valid/ready flow
// control and a per-transaction signed/unsigned mode.
//
// Parameters:
//   bit_width  operand width per lane
//   prd_width  output product width per lane (2..2*bit_width)
//   n_lanes    parallel multiplies per transaction
//   stages     pipeline latency in cycles (1..4)
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_valid/o_ready  input handshake (o_ready = !o_valid || i_ready)
//   i_signed         1: two's-complement operands, 0: unsigned
//   i_op0, i_op1     packed operands, lane k at [k*bit_width +: bit_width]
//   o_valid/i_ready  output handshake
//   o_prd            packed products, lane k at [k*prd_width +: prd_width]
//   o_ovf            per-lane flag: full product did not fit in prd_width
//
// Build option:
//   MUL_INT_PIPE_SAT_EN  defined: overflowed lanes saturate;
//                        undefined: overflowed lanes wrap (low prd_width bits).
module mul_int_pipe #(
  parameter int unsigned bit_width = 8,
  parameter int unsigned prd_width = 2 * bit_width,
  parameter int unsigned n_lanes   = 4,
  parameter int unsigned stages    = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic                           i_signed,
  input  logic [n_lanes*bit_width-1:0]   i_op0,
  input  logic [n_lanes*bit_width-1:0]   i_op1,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [n_lanes*prd_width-1:0]   o_prd,
  output logic [n_lanes-1:0]             o_ovf
);

  localparam int unsigned FW = 2 * bit_width;
  localparam int unsigned LW = n_lanes * bit_width;
  localparam int unsigned PW = n_lanes * FW;
  localparam int unsigned OW = n_lanes * prd_width;
  localparam logic [FW-1:0] ONE = FW'(1);

  // Sign-magnitude multiply carried out in FW bits: |a|*|b| never exceeds
  // 2^(FW-2) in signed mode, so the magnitude of the most negative operand
  // stays exact. Unsigned operands zero-extend and skip the sign fix-up.
  function automatic logic [FW-1:0] full_mul(input logic [bit_width-1:0] a,
                                             input logic [bit_width-1:0] b,
                                             input logic                 sgn);
    logic [FW-1:0] ea, eb, ma, mb, mp;
    logic          neg;
    ea  = {{bit_width{sgn & a[bit_width-1]}}, a};
    eb  = {{bit_width{sgn & b[bit_width-1]}}, b};
    ma  = ea[FW-1] ? (~ea + ONE) : ea;
    mb  = eb[FW-1] ? (~eb + ONE) : eb;
    mp  = ma * mb;
    neg = (ea[FW-1] ^ eb[FW-1]) && (mp != '0);
    return neg ? (~mp + ONE) : mp;
  endfunction

  // Returns {ovf, narrowed value}. Signed fit: all bits at and above
  // prd_width-1 agree. Unsigned fit: all bits at and above prd_width are zero.
  function automatic logic [prd_width:0] narrow(input logic [FW-1:0] p,
                                                input logic          sgn);
    logic                 ovf;
    logic [prd_width-1:0] v;
    ovf = 1'b0;
    for (int unsigned i = prd_width; i < FW; i++) begin
      ovf = ovf | (sgn ? (p[i] != p[prd_width-1]) : p[i]);
    end
    v = p[prd_width-1:0];
`ifdef MUL_INT_PIPE_SAT_EN
    if (ovf) begin
      if (sgn) begin
        v = p[FW-1] ? {1'b1, {(prd_width-1){1'b0}}} : {1'b0, {(prd_width-1){1'b1}}};
      end else begin
        v = '1;
      end
    end
`endif
    return {ovf, v};
  endfunction

  // Valid bits: index 0 is the first register level, stages-1 drives o_valid.
  logic [stages-1:0] vld_q, vld_d;
  logic              advance;

  assign advance = !vld_q[stages-1] || i_ready;
  assign o_ready = advance;
  assign o_valid = vld_q[stages-1];

  always_comb begin
    vld_d = vld_q;
    if (advance) begin
      vld_d[0] = i_valid;
      for (int unsigned s = 1; s < stages; s++) begin
        vld_d[s] = vld_q[s-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Multiplier operands: registered first level, or taken straight from the
  // ports when the whole pipeline is a single level.
  logic [LW-1:0] m_op0, m_op1;
  logic          m_sgn;

  if (stages == 1) begin : g_front_pass
    assign m_op0 = i_op0;
    assign m_op1 = i_op1;
    assign m_sgn = i_signed;
  end else begin : g_front_reg
    logic [LW-1:0] op0_q, op1_q;
    logic          sgn_q;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        op0_q <= '0;
        op1_q <= '0;
        sgn_q <= 1'b0;
      end else if (advance && vld_d[0]) begin
        op0_q <= i_op0;
        op1_q <= i_op1;
        sgn_q <= i_signed;
      end
    end
    assign m_op0 = op0_q;
    assign m_op1 = op1_q;
    assign m_sgn = sgn_q;
  end

  logic [PW-1:0] m_full;

  always_comb begin
    m_full = '0;
    for (int unsigned k = 0; k < n_lanes; k++) begin
      m_full[k*FW +: FW] = full_mul(m_op0[k*bit_width +: bit_width],
                                    m_op1[k*bit_width +: bit_width], m_sgn);
    end
  end

  // Intermediate levels carry the exact full-width product and its mode.
  logic [PW-1:0] f_full;
  logic          f_sgn;

  if (stages >= 3) begin : g_mid
    localparam int unsigned NM = stages - 2;
    logic [PW-1:0] full_q [NM];
    logic [NM-1:0] msgn_q;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int unsigned j = 0; j < NM; j++) begin
          full_q[j] <= '0;
        end
        msgn_q <= '0;
      end else if (advance) begin
        if (vld_d[1]) begin
          full_q[0] <= m_full;
          msgn_q[0] <= m_sgn;
        end
        for (int unsigned j = 1; j < NM; j++) begin
          if (vld_d[j+1]) begin
            full_q[j] <= full_q[j-1];
            msgn_q[j] <= msgn_q[j-1];
          end
        end
      end
    end
    assign f_full = full_q[NM-1];
    assign f_sgn  = msgn_q[NM-1];
  end else begin : g_mid_pass
    assign f_full = m_full;
    assign f_sgn  = m_sgn;
  end

  // Final level: narrowed product and overflow flags.
  logic [OW-1:0]      prd_q, prd_d;
  logic [n_lanes-1:0] ovf_q, ovf_d;

  always_comb begin
    prd_d = prd_q;
    ovf_d = ovf_q;
    if (advance && vld_d[stages-1]) begin
      for (int unsigned k = 0; k < n_lanes; k++) begin
        {ovf_d[k], prd_d[k*prd_width +: prd_width]} = narrow(f_full[k*FW +: FW], f_sgn);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prd_q <= '0;
      ovf_q <= '0;
    end else begin
      prd_q <= prd_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_prd = prd_q;
  assign o_ovf = ovf_q;

endmodule

// File: tb/tb_mul_int_pipe.sv
`timescale 1ns/1ps
module tb_mul_int_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_signed = 1'b0;
  logic        i_ready = 1'b1;
  logic [31:0] i_op0 = '0;
  logic [31:0] i_op1 = '0;
  logic        o_ready, o_valid, o_ready8, o_valid8;
  logic [63:0] o_prd;
  logic [3:0]  o_ovf;
  logic [31:0] o_prd8;
  logic [3:0]  o_ovf8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_int_pipe #(.bit_width(8), .prd_width(16), .n_lanes(4), .stages(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_signed(i_signed), .i_op0(i_op0), .i_op1(i_op1),
    .o_valid(o_valid), .i_ready(i_ready), .o_prd(o_prd), .o_ovf(o_ovf)
  );

  mul_int_pipe #(.bit_width(8), .prd_width(8), .n_lanes(4), .stages(2)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready8),
    .i_signed(i_signed), .i_op0(i_op0), .i_op1(i_op1),
    .o_valid(o_valid8), .i_ready(i_ready), .o_prd(o_prd8), .o_ovf(o_ovf8)
  );

  typedef struct packed {
    logic [63:0] p16;
    logic [3:0]  f16;
    logic [31:0] p8;
    logic [3:0]  f8;
  } exp_t;

  // Reference: exact integer product, range test against the output width,
  // then saturate or wrap.
  function automatic logic [15:0] ref_lane(input logic [7:0] a, input logic [7:0] b,
                                           input logic s, input int w, output logic ovf);
    longint p, lo, hi, v;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'(a) * longint'(b);
    if (s) begin
      lo = -(longint'(1) << (w - 1));
      hi = (longint'(1) << (w - 1)) - 1;
    end else begin
      lo = 0;
      hi = (longint'(1) << w) - 1;
    end
    ovf = (p < lo) || (p > hi);
    v = p;
`ifdef MUL_INT_PIPE_SAT_EN
    if (ovf) v = (p < lo) ? lo : hi;
`endif
    return 16'(v & ((longint'(1) << w) - 1));
  endfunction

  function automatic exp_t make_exp(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t        e;
    logic        f;
    logic [15:0] v;
    e = '0;
    for (int k = 0; k < 4; k++) begin
      v = ref_lane(a[k*8 +: 8], b[k*8 +: 8], s, 16, f);
      e.p16[k*16 +: 16] = v;
      e.f16[k] = f;
      v = ref_lane(a[k*8 +: 8], b[k*8 +: 8], s, 8, f);
      e.p8[k*8 +: 8] = v[7:0];
      e.f8[k] = f;
    end
    return e;
  endfunction

  function automatic logic [31:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [63:0] pk16(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  // Drives one transaction into an empty pipeline and captures what both
  // DUTs show one and two edges after acceptance.
  task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic s,
                            output logic v_early, output logic v_late,
                            output logic [63:0] p16, output logic [3:0] f16,
                            output logic [31:0] p8, output logic [3:0] f8);
    @(posedge clk); #1;
    i_valid = 1'b1; i_op0 = a; i_op1 = b; i_signed = s; i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_op0 = $urandom; i_op1 = $urandom; i_signed = 1'($urandom_range(0, 1));
    v_early = o_valid;
    @(posedge clk); #1;
    v_late = o_valid && o_valid8;
    p16 = o_prd; f16 = o_ovf; p8 = o_prd8; f8 = o_ovf8;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (o_valid !== 1'b0 || o_valid8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b/%b want 0/0", o_valid, o_valid8);
    end
    n_tests++;
    if (o_prd !== 64'h0 || o_ovf !== 4'h0 || o_prd8 !== 32'h0 || o_ovf8 !== 4'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h %h want zeros", o_prd, o_ovf, o_prd8, o_ovf8);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (o_ready !== 1'b1 || o_ready8 !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b/%b want 1/1", o_ready, o_ready8);
    end
    i_ready = 1'b1;
  endtask

  task automatic test_signed();
    logic ve, vl; logic [63:0] p16; logic [3:0] f16; logic [31:0] p8; logic [3:0] f8;
    logic [31:0] a, b; exp_t e;
    a = pk(-128, -128, -1, 0);
    b = pk(-128, 127, 1, -5);
    e = make_exp(a, b, 1'b1);
    run_single(a, b, 1'b1, ve, vl, p16, f16, p8, f8);
    n_tests++;
    if (ve !== 1'b0 || vl !== 1'b1) begin
      n_fail++; $display("FAIL signed_latency: got early=%b late=%b want 0 1", ve, vl);
    end
    n_tests++;
    if (p16 !== pk16(16384, -16256, -1, 0) || f16 !== 4'h0) begin
      n_fail++; $display("FAIL signed_prd16: got %h ovf %b want %h ovf 0000", p16, f16, pk16(16384, -16256, -1, 0));
    end
    n_tests++;
    if (p8 !== e.p8 || f8 !== e.f8) begin
      n_fail++; $display("FAIL signed_prd8: got %h ovf %b want %h ovf %b", p8, f8, e.p8, e.f8);
    end
  endtask

  task automatic test_unsigned();
    logic ve, vl; logic [63:0] p16; logic [3:0] f16; logic [31:0] p8; logic [3:0] f8;
    logic [31:0] a, b; exp_t e;
    a = pk(255, 128, 0, 1);
    b = pk(255, 2, 0, 7);
    e = make_exp(a, b, 1'b0);
    run_single(a, b, 1'b0, ve, vl, p16, f16, p8, f8);
    n_tests++;
    if (vl !== 1'b1 || p16 !== pk16(65025, 256, 0, 7) || f16 !== 4'h0) begin
      n_fail++; $display("FAIL unsigned_prd16: got v=%b %h ovf %b want %h ovf 0000", vl, p16, f16, pk16(65025, 256, 0, 7));
    end
    n_tests++;
    if (p8 !== e.p8 || f8 !== e.f8) begin
      n_fail++; $display("FAIL unsigned_prd8: got %h ovf %b want %h ovf %b", p8, f8, e.p8, e.f8);
    end
  endtask

  task automatic test_narrow();
    logic ve, vl; logic [63:0] p16; logic [3:0] f16; logic [31:0] p8; logic [3:0] f8;
    logic [31:0] want8;
    run_single(pk(16, 15, -16, 16), pk(8, -8, 8, -9), 1'b1, ve, vl, p16, f16, p8, f8);
`ifdef MUL_INT_PIPE_SAT_EN
    want8 = pk(127, -120, -128, -128);
`else
    want8 = pk(-128, -120, -128, 112);
`endif
    n_tests++;
    if (vl !== 1'b1 || p8 !== want8 || f8 !== 4'b1001) begin
      n_fail++; $display("FAIL narrow_prd8: got v=%b %h ovf %b want %h ovf 1001", vl, p8, f8, want8);
    end
    n_tests++;
    if (p16 !== pk16(128, -120, -128, -144) || f16 !== 4'h0) begin
      n_fail++; $display("FAIL narrow_prd16: got %h ovf %b want %h ovf 0000", p16, f16, pk16(128, -120, -128, -144));
    end
  endtask

  task automatic test_back_to_back();
    exp_t e1, e2;
    e1 = make_exp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    e2 = make_exp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    @(posedge clk); #1;
    i_valid = 1'b1; i_op0 = 32'hFFFF_FFFF; i_op1 = 32'hFFFF_FFFF; i_signed = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    i_signed = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_signed = 1'b0;
    n_tests++;
    if (o_valid !== 1'b1 || o_prd !== pk16(65025, 65025, 65025, 65025) || o_ovf !== 4'h0) begin
      n_fail++; $display("FAIL b2b_first: got v=%b %h ovf %b want 1 fe01 x4", o_valid, o_prd, o_ovf);
    end
    n_tests++;
    if (o_prd8 !== e1.p8 || o_ovf8 !== e1.f8) begin
      n_fail++; $display("FAIL b2b_first8: got %h ovf %b want %h ovf %b", o_prd8, o_ovf8, e1.p8, e1.f8);
    end
    @(posedge clk); #1;
    n_tests++;
    if (o_valid !== 1'b1 || o_prd !== pk16(1, 1, 1, 1) || o_ovf !== 4'h0) begin
      n_fail++; $display("FAIL b2b_second: got v=%b %h ovf %b want 1 0001 x4", o_valid, o_prd, o_ovf);
    end
    n_tests++;
    if (o_prd8 !== e2.p8 || o_ovf8 !== e2.f8) begin
      n_fail++; $display("FAIL b2b_second8: got %h ovf %b want %h ovf %b", o_prd8, o_ovf8, e2.p8, e2.f8);
    end
  endtask

  // Streams n random transactions; ready follows 1,0,0,1 or is random.
  task automatic test_backpressure(input int n, input bit rnd, input string name);
    logic [31:0] sa[$], sb[$];
    logic        ss[$];
    exp_t        q[$];
    exp_t        e;
    int          sent, got, cyc;
    bit          stall_prev, extra;
    logic [63:0] h16; logic [3:0] hf16; logic [31:0] h8; logic [3:0] hf8;
    sent = 0; got = 0; cyc = 0; stall_prev = 0; extra = 0;
    h16 = '0; hf16 = '0; h8 = '0; hf8 = '0;
    for (int i = 0; i < n; i++) begin
      sa.push_back($urandom); sb.push_back($urandom); ss.push_back(1'($urandom_range(0, 1)));
    end
    while (got < n && cyc < 600) begin
      @(posedge clk); #1;
      i_ready = rnd ? ($urandom_range(0, 2) != 0) : ((cyc % 4 == 0) || (cyc % 4 == 3));
      i_valid = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (sent < n) begin
        i_op0 = sa[sent]; i_op1 = sb[sent]; i_signed = ss[sent];
      end else begin
        i_op0 = $urandom; i_op1 = $urandom; i_signed = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n_tests++;
      if (o_ready !== (!o_valid || i_ready) || o_ready8 !== (!o_valid8 || i_ready)) begin
        n_fail++; $display("FAIL %s_ready: got %b/%b with o_valid=%b i_ready=%b", name, o_ready, o_ready8, o_valid, i_ready);
      end
      if (stall_prev) begin
        n_tests++;
        if (o_valid !== 1'b1 || o_prd !== h16 || o_ovf !== hf16 || o_prd8 !== h8 || o_ovf8 !== hf8) begin
          n_fail++; $display("FAIL %s_hold: got v=%b %h %b %h %b want 1 %h %b %h %b",
                             name, o_valid, o_prd, o_ovf, o_prd8, o_ovf8, h16, hf16, h8, hf8);
        end
      end
      if (o_valid === 1'b1 && i_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL %s_extra: got unexpected output %h want none", name, o_prd);
          extra = 1;
        end else begin
          e = q.pop_front();
          got++;
          if ({o_prd, o_ovf, o_prd8, o_ovf8, o_valid8} !== {e.p16, e.f16, e.p8, e.f8, 1'b1}) begin
            n_fail++; $display("FAIL %s_data: item %0d got %h %b %h %b v8=%b want %h %b %h %b",
                               name, got - 1, o_prd, o_ovf, o_prd8, o_ovf8, o_valid8, e.p16, e.f16, e.p8, e.f8);
          end
        end
      end
      if (i_valid && o_ready) begin
        q.push_back(make_exp(sa[sent], sb[sent], ss[sent]));
        sent++;
      end
      stall_prev = (o_valid === 1'b1) && !i_ready;
      h16 = o_prd; hf16 = o_ovf; h8 = o_prd8; hf8 = o_ovf8;
      cyc++;
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_ready = 1'b1;
    n_tests++;
    if (got != n || q.size() != 0 || extra) begin
      n_fail++; $display("FAIL %s_count: got %0d outputs (queue %0d) want %0d", name, got, q.size(), n);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (o_valid !== 1'b0 || o_valid8 !== 1'b0) begin
      n_fail++; $display("FAIL %s_drain: got o_valid=%b/%b want 0/0", name, o_valid, o_valid8);
    end
  endtask

  task automatic test_reset_flight();
    bit seen;
    @(posedge clk); #1;
    i_ready = 1'b0; i_valid = 1'b1; i_signed = 1'b0;
    i_op0 = pk(3, 4, 5, 6); i_op1 = pk(7, 7, 7, 7);
    @(posedge clk); #1;
    i_op0 = pk(9, 9, 9, 9);
    @(posedge clk); #1;
    i_valid = 1'b0;
    n_tests++;
    if (o_valid !== 1'b1 || o_prd !== pk16(21, 28, 35, 42)) begin
      n_fail++; $display("FAIL flight_pre: got v=%b %h want 1 %h", o_valid, o_prd, pk16(21, 28, 35, 42));
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (o_valid !== 1'b0 || o_valid8 !== 1'b0 || o_prd !== 64'h0 || o_ovf !== 4'h0 || o_ready !== 1'b1) begin
      n_fail++; $display("FAIL flight_reset: got v=%b/%b prd=%h ovf=%b rdy=%b want 0/0 0 0 1",
                         o_valid, o_valid8, o_prd, o_ovf, o_ready);
    end
    rst = 1'b0; i_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (o_valid !== 1'b0 || o_valid8 !== 1'b0) seen = 1;
    end
    n_tests++;
    if (seen) begin
      n_fail++; $display("FAIL flight_stale: got o_valid=1 after reset want 0");
    end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_narrow();
    test_back_to_back();
    test_backpressure(8, 1'b0, "bp");
    test_backpressure(40, 1'b1, "rand");
    test_reset_flight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
